oai33_bist: RTL

Built-in self-test sequencer that sits directly upstream and downstream of a 6-input OAI33 cell instance. It drives all 64 input combinations onto A1..A3/B1..B3 and samples the cell's ZN output. Each sample is checked against an internal golden OAI33 model and folded into a 16-bit MISR signature. It runs the cell-level functional check on silicon or in gate-level simulation without external pattern hardware.

---
 rtl/oai33_bist_if.sv | 20 ++
 rtl/oai33_bist.sv | 120 ++++++++++++
 2 files changed

// File: rtl/oai33_bist_if.sv
// Stimulus/response bundle between the BIST sequencer and the OAI33 cell under test.
interface oai33_bist_if;
    logic A1;
    logic A2;
    logic A3;
    logic B1;
    logic B2;
    logic B3;
    logic ZN;

    modport master (
        output A1, A2, A3, B1, B2, B3,
        input  ZN
    );

    modport slave (
        input  A1, A2, A3, B1, B2, B3,
        output ZN
    );
endinterface

// File: rtl/oai33_bist.sv
// Exhaustive 64-vector BIST for an OAI33 cell: golden compare plus 16-bit MISR signature.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for start after reset
// S_SETTLE | current vector held while the cell propagates
// S_SAMPLE | ZN captured, compared and folded into the MISR
// S_DONE   | results frozen; start launches a fresh run
module oai33_bist #(
    parameter int          SETTLE_CYC = 2,
    parameter logic [15:0] SIG_SEED   = 16'hFFFF
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    oai33_bist_if.master     cut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [6:0]       err_count,
    output logic [15:0]      signature
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [15:0] MISR_POLY   = 16'h1021;

    state_t      state_q, state_d;
    logic [5:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  err_q, err_d;
    logic [15:0] sig_q, sig_d;
    logic        busy_q, done_q, pass_q;
    logic        exp_zn;
    logic        mismatch;

    assign exp_zn   = ~((vec_q[0] | vec_q[1] | vec_q[2]) & (vec_q[3] | vec_q[4] | vec_q[5]));
    assign mismatch = cut.ZN ^ exp_zn;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            sig_q   <= SIG_SEED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            sig_q   <= sig_d;
            busy_q  <= (state_d == S_SETTLE) || (state_d == S_SAMPLE);
            done_q  <= (state_d == S_DONE);
            pass_q  <= (state_d == S_DONE) && (err_d == 7'd0);
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        sig_d   = sig_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    sig_d   = SIG_SEED;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                err_d = err_q + 7'(mismatch);
                sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ cut.ZN) ? MISR_POLY : 16'h0000);
                if (vec_q == 6'd63) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 6'd1;
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stimulus pins come straight off the vector register, so they are glitch-free.
    assign cut.A1 = vec_q[0];
    assign cut.A2 = vec_q[1];
    assign cut.A3 = vec_q[2];
    assign cut.B1 = vec_q[3];
    assign cut.B2 = vec_q[4];
    assign cut.B3 = vec_q[5];

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign signature = sig_q;

endmodule
